load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle memory-access stage of the Vermicel core. Executes RV32I loads and stores over the single-master data bus and produces the aligned, extended load result. It then drives that result, with a one-cycle write-enable, into the register file write port (`xd`/`enable`). The unit sits between the execute stage, which supplies the effective address and the `xs2` store data, and register writeback.

## Interface
Parameters:
- none; data width is fixed by `word_t` (32 bits), byte lanes = 4

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request: `instr` is in the memory stage
- `instr`  in  instruction_t  decoded instruction; uses `is_load`, `is_store`, `funct3`, `has_rd`, `rd`
- `address`  in  word_t  effective address from the ALU; sampled with `start`
- `store_data`  in  word_t  `xs2` value; sampled with `start`
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `fault`  out  1  one-cycle pulse coincident with `done` on a misaligned access
- `xd`  out  word_t  load result for the register file
- `wb_enable`  out  1  register-file write enable, coincident with `done`
- `mem_valid`  out  1  bus request
- `mem_ready`  in  1  bus acknowledge
- `mem_address`  out  word_t  word-aligned bus address
- `mem_wstrobe`  out  4  byte-lane write enables; 0 for reads
- `mem_wdata`  out  word_t  lane-replicated store data
- `mem_rdata`  in  word_t  read data, valid when `mem_valid && mem_ready`

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE with `start`:
  - Latch `instr`, `address` and `store_data`.
  - Non-memory instruction → DONE with no bus activity and `wb_enable=0`.
  - Misaligned access → DONE with `fault=1` and no bus activity. Misaligned means: word access with `address[1:0]≠0`, or halfword access with `address[0]≠0`.
  - Otherwise → ACCESS.
- ACCESS:
  - `mem_valid=1`. `mem_address`, `mem_wstrobe` and `mem_wdata` are held stable until `mem_ready`.
  - On `mem_ready`: for a load, capture the extracted `mem_rdata` into the `xd` register; then → DONE.
- DONE:
  - `done=1`.
  - `wb_enable = is_load && has_rd && rd≠0`. The register file does not filter x0, so the unit gates it here.
  - → IDLE.
- Store strobes, with `a = address[1:0]`:
  - SB: `mem_wstrobe = 1<<a`; `mem_wdata` = byte replicated on all 4 lanes.
  - SH: `mem_wstrobe = 3<<a`; `mem_wdata` = halfword replicated on both halves.
  - SW: `mem_wstrobe = 4'b1111`.
- Load extraction: shift `mem_rdata` right by 8·a.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- `mem_address = {address[31:2], 2'b00}`.
- `start` while `busy` is ignored.
- An unknown load/store `funct3` is treated as misaligned and raises `fault`.

## Timing
- Reset values: `busy`, `done`, `fault`, `wb_enable`, `mem_valid` = 0; `mem_wstrobe` = 0; `xd`, `mem_address`, `mem_wdata` = 0.
- Latency:
  - `start` at cycle 0 → `mem_valid` high at cycle 1.
  - `mem_ready` at cycle k ≥ 1 → `done`/`wb_enable` at cycle k+1.
  - Minimum total latency is 2 cycles.
  - Non-memory or faulting access: `done` at cycle 1.
- Zero-wait bus: `mem_ready` may be high in the first ACCESS cycle.
- `xd` stays valid from the `done` cycle until the next load completes.
- Reset asserted mid-ACCESS drops `mem_valid` immediately (asynchronous). The bus is responsible for discarding the transaction.

## Structure
- `types_pkg`: `lsu_state_t` enum {IDLE, ACCESS, DONE}.
- `opcodes_pkg`: load/store `funct3` constants (`FUNCT3_LB`, `FUNCT3_LH`, `FUNCT3_LW`, `FUNCT3_LBU`, `FUNCT3_LHU`, `FUNCT3_SB`, `FUNCT3_SH`, `FUNCT3_SW`).
- Sub-module `load_aligner`: combinational extraction of `mem_rdata` with sign/zero-extension, driven by `funct3` and `address[1:0]`.
- The FSM and store-strobe logic stay in `load_store_unit`.

## Test plan
- LW x5 at 0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` in the first ACCESS cycle → `mem_address`=0x100, `mem_wstrobe`=0, `done`+`wb_enable` at cycle 2, `xd`=0xDEADBEEF.
- LB and LBU at 0x103, `mem_rdata`=0x80112233 → `xd`=0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202, `store_data`=0x1234ABCD, `mem_ready` delayed 3 cycles → `mem_wstrobe`=4'b1100, `mem_wdata`=0xABCDABCD, held stable for 4 cycles; `wb_enable`=0.
- LW at 0x101 → `fault`+`done` at cycle 1, `mem_valid` never asserted, `wb_enable`=0.
- LW with `rd`=0 → bus access completes, `wb_enable`=0; a second `start` while `busy` is ignored.
- `reset` pulled low during ACCESS → `mem_valid`/`busy` drop in the same cycle; after release a new LW completes normally.

Source files
------------

// File: rtl/opcodes_pkg.sv
// RV32I load/store funct3 encodings and the access legality check derived from them.
package opcodes_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Store encodings share the low load encodings; the unsigned forms exist only for loads,
  // and any funct3 outside the defined set is reported as a fault.
  function automatic logic access_fault(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic w_fault;
    w_fault = 1'b1;
    case (funct3)
      FUNCT3_LB:  w_fault = 1'b0;
      FUNCT3_LH:  w_fault = offset[0];
      FUNCT3_LW:  w_fault = |offset;
      FUNCT3_LBU: w_fault = is_store;
      FUNCT3_LHU: w_fault = is_store | offset[0];
      default:    w_fault = 1'b1;
    endcase
    return w_fault;
  endfunction

endpackage

// File: rtl/types_pkg.sv
// Shared data types for the load/store unit: bus word, decoded instruction fields, FSM states.
package types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [2:0] funct3;
    logic       has_rd;
    logic [4:0] rd;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/load_aligner.sv
// Extracts the addressed byte/halfword/word from a bus read word and sign- or zero-extends it.
// Purely combinational.
module load_aligner
  import types_pkg::*;
  import opcodes_pkg::*;
(
  input  word_t      i_rdata,
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_offset,
  output word_t      o_data
);

  word_t w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_funct3)
      FUNCT3_LB:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      FUNCT3_LH:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      FUNCT3_LBU: o_data = {24'd0, w_shifted[7:0]};
      FUNCT3_LHU: o_data = {16'd0, w_shifted[15:0]};
      default:    o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one load or store over the data bus and hands the aligned load
// result to register writeback with a single-cycle write enable.
module load_store_unit
  import types_pkg::*;
  import opcodes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  instruction_t instr,
  input  word_t        address,
  input  word_t        store_data,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output word_t        xd,
  output logic         wb_enable,
  output logic         mem_valid,
  input  logic         mem_ready,
  output word_t        mem_address,
  output logic [3:0]   mem_wstrobe,
  output word_t        mem_wdata,
  input  word_t        mem_rdata
);

  lsu_state_t   r_state;
  lsu_state_t   w_next_state;
  instruction_t r_instr;
  word_t        r_address;
  word_t        r_store_data;
  logic         r_fault;
  word_t        r_xd;
  word_t        w_load_data;
  logic         w_is_mem;
  logic         w_start_fault;
  logic         w_accept;

  assign w_is_mem      = instr.is_load | instr.is_store;
  assign w_start_fault = w_is_mem & access_fault(instr.is_store, instr.funct3, address[1:0]);
  assign w_accept      = (r_state == IDLE) & start;

  load_aligner u_load_aligner (
    .i_rdata  (mem_rdata),
    .i_funct3 (r_instr.funct3),
    .i_offset (r_address[1:0]),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_instr      <= '0;
      r_address    <= '0;
      r_store_data <= '0;
      r_fault      <= 1'b0;
      r_xd         <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_instr      <= instr;
        r_address    <= address;
        r_store_data <= store_data;
        r_fault      <= w_start_fault;
      end
      if ((r_state == ACCESS) && mem_ready && r_instr.is_load) begin
        r_xd <= w_load_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    fault        = 1'b0;
    wb_enable    = 1'b0;
    mem_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (!w_is_mem || w_start_fault) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        if (mem_ready) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        fault        = r_fault;
        // x0 is not filtered by the register file, so it is suppressed here.
        wb_enable    = r_instr.is_load & r_instr.has_rd & (r_instr.rd != 5'd0) & ~r_fault;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_wstrobe = 4'b0000;
    if (mem_valid && r_instr.is_store) begin
      case (r_instr.funct3)
        FUNCT3_SB: mem_wstrobe = 4'b0001 << r_address[1:0];
        FUNCT3_SH: mem_wstrobe = 4'b0011 << r_address[1:0];
        FUNCT3_SW: mem_wstrobe = 4'b1111;
        default:   mem_wstrobe = 4'b0000;
      endcase
    end
  end

  always_comb begin
    mem_wdata = r_store_data;
    case (r_instr.funct3)
      FUNCT3_SB: mem_wdata = {4{r_store_data[7:0]}};
      FUNCT3_SH: mem_wdata = {2{r_store_data[15:0]}};
      default:   mem_wdata = r_store_data;
    endcase
  end

  assign mem_address = {r_address[31:2], 2'b00};
  assign xd          = r_xd;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized transactions against a byte-level model.
module tb_load_store_unit;
  import types_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  instruction_t instr;
  word_t        address;
  word_t        store_data;
  logic         busy, done, fault, wb_enable, mem_valid, mem_ready;
  word_t        xd, mem_address, mem_wdata, mem_rdata;
  logic [3:0]   mem_wstrobe;

  int    n_checks = 0;
  int    n_errors = 0;
  word_t m_xd = 32'd0;

  load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .address     (address),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .xd          (xd),
    .wb_enable   (wb_enable),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_address (mem_address),
    .mem_wstrobe (mem_wstrobe),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: drive start, play the bus with the given wait count, check every cycle.
  task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic hrd, input logic [4:0] rd, input word_t addr,
                         input word_t sd, input word_t rdata, input int wait_cyc,
                         input logic poke);
    int         size;
    logic       bad;
    logic       is_mem;
    int         a;
    word_t      sh, exp_xd, exp_wdata, junk;
    logic [3:0] exp_strb;
    logic       exp_wb;

    is_mem = ld | st;
    size   = 0;
    bad    = 1'b0;
    a      = int'(addr % 4);
    if (ld) begin
      case (f3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    bad = 1'b1;
      endcase
    end else if (st) begin
      case (f3)
        3'd0:    size = 1;
        3'd1:    size = 2;
        3'd2:    size = 4;
        default: bad = 1'b1;
      endcase
    end
    if (is_mem && !bad && (addr % size) != 0) bad = 1'b1;

    sh = rdata >> (8 * a);
    case (f3)
      3'd0:    exp_xd = {{24{sh[7]}}, sh[7:0]};
      3'd1:    exp_xd = {{16{sh[15]}}, sh[15:0]};
      3'd4:    exp_xd = sh & 32'h0000_00FF;
      3'd5:    exp_xd = sh & 32'h0000_FFFF;
      default: exp_xd = rdata;
    endcase
    exp_strb  = 4'b0000;
    exp_wdata = sd;
    if (st && size == 1) begin exp_strb = 4'(1 << a); exp_wdata = {4{sd[7:0]}}; end
    if (st && size == 2) begin exp_strb = 4'(3 << a); exp_wdata = {2{sd[15:0]}}; end
    if (st && size == 4) exp_strb = 4'hF;
    exp_wb = ld && hrd && (rd != 5'd0);

    instr.is_load  = ld;
    instr.is_store = st;
    instr.funct3   = f3;
    instr.has_rd   = hrd;
    instr.rd       = rd;
    address        = addr;
    store_data     = sd;
    start          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    if (!is_mem || bad) begin
      check("short_done", {31'd0, done}, 32'd1);
      check("short_fault", {31'd0, fault}, {31'd0, bad});
      check("short_wb", {31'd0, wb_enable}, 32'd0);
      check("short_valid", {31'd0, mem_valid}, 32'd0);
      check("short_xd", xd, m_xd);
    end else begin
      for (int i = 0; i <= wait_cyc; i++) begin
        check("acc_valid", {31'd0, mem_valid}, 32'd1);
        check("acc_busy", {31'd0, busy}, 32'd1);
        check("acc_done", {31'd0, done}, 32'd0);
        check("acc_addr", mem_address, addr & 32'hFFFF_FFFC);
        check("acc_strb", {28'd0, mem_wstrobe}, {28'd0, exp_strb});
        if (st) check("acc_wdata", mem_wdata, exp_wdata);
        junk      = $urandom;
        mem_ready = (i == wait_cyc);
        mem_rdata = (i == wait_cyc) ? rdata : junk;
        if (poke && i == 0) begin
          start   = 1'b1;
          address = $urandom;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      mem_ready = 1'b0;
      check("done", {31'd0, done}, 32'd1);
      check("done_fault", {31'd0, fault}, 32'd0);
      check("done_wb", {31'd0, wb_enable}, {31'd0, exp_wb});
      if (ld) m_xd = exp_xd;
      check("done_xd", xd, m_xd);
    end
    @(posedge clk); #1;
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic        ld, st;
    logic [2:0]  f3;
    word_t       addr;

    reset      = 1'b0;
    start      = 1'b0;
    instr      = '0;
    address    = '0;
    store_data = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_wb", {31'd0, wb_enable}, 32'd0);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_strb", {28'd0, mem_wstrobe}, 32'd0);
    check("rst_xd", xd, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_txn(1, 0, 3'd2, 1, 5'd5, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    run_txn(1, 0, 3'd0, 1, 5'd6, 32'h103, 32'h0, 32'h80112233, 0, 0);
    run_txn(1, 0, 3'd4, 1, 5'd7, 32'h103, 32'h0, 32'h80112233, 1, 0);
    run_txn(0, 1, 3'd1, 0, 5'd0, 32'h202, 32'h1234ABCD, 32'h0, 3, 0);
    run_txn(1, 0, 3'd2, 1, 5'd8, 32'h101, 32'h0, 32'h0, 0, 0);
    run_txn(1, 0, 3'd2, 1, 5'd0, 32'h104, 32'h0, 32'h5555AAAA, 2, 1);
    run_txn(0, 0, 3'd0, 1, 5'd9, 32'h0, 32'h0, 32'h0, 0, 0);

    // Asynchronous reset in the middle of a bus access.
    instr      = '{is_load: 1'b1, is_store: 1'b0, funct3: 3'd2, has_rd: 1'b1, rd: 5'd3};
    address    = 32'h40;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, mem_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_xd", xd, 32'd0);
    m_xd = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_txn(1, 0, 3'd2, 1, 5'd3, 32'h40, 32'h0, 32'hCAFEF00D, 1, 0);

    for (int n = 0; n < 300; n++) begin
      r    = $urandom;
      ld   = (r[3:0] < 4'd7);
      st   = !ld && (r[3:0] < 4'd14);
      f3   = r[6:4];
      addr = $urandom;
      if (r[7]) addr[1:0] = 2'b00;
      run_txn(ld, st, f3, r[8], r[13:9], addr, $urandom, $urandom,
              int'($urandom_range(0, 3)), r[14]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
